// File: rtl/mure_pkg.sv
// Shared trace-encoder definitions: itype encoding and branch-map sizing.
package mure_pkg;

    localparam int ITYPE_LEN      = 3;
    localparam int BRANCH_MAP_LEN = 31;
    localparam int BRANCH_CNT_LEN = 5;

    localparam logic [ITYPE_LEN-1:0] ITYPE_NOT_TAKEN = 3'd4;
    localparam logic [ITYPE_LEN-1:0] ITYPE_TAKEN     = 3'd5;

    function automatic logic is_branch(input logic [ITYPE_LEN-1:0] itype);
        return (itype == ITYPE_NOT_TAKEN) || (itype == ITYPE_TAKEN);
    endfunction

endpackage

// File: rtl/te_branch_map_compactor.sv
// Packs the outcomes of this cycle's conditional-branch lanes, in lane order,
// into the low bits of a vector (1 = not taken) and counts them.
module te_branch_lane_compactor
    import mure_pkg::*;
#(
    parameter int N    = 1,
    parameter int NB_W = $clog2(N + 1)
) (
    input  logic [N-1:0]                valid,
    input  logic [N-1:0][ITYPE_LEN-1:0] itype,
    output logic [NB_W-1:0]             nb,
    output logic [N-1:0]                outcome
);

    // Walk lanes in ascending order, appending each branch outcome at the next free slot.
    always_comb begin
        nb      = {NB_W{1'b0}};
        outcome = {N{1'b0}};
        for (int k = 0; k < N; k++) begin
            if (valid[k] && is_branch(itype[k])) begin
                outcome = outcome | (N'(itype[k] == ITYPE_NOT_TAKEN) << nb);
                nb      = nb + NB_W'(1'b1);
            end else begin
                nb      = nb;
            end
        end
    end

endmodule

// File: rtl/te_branch_map.sv
// Branch-map accumulator: records retired conditional-branch outcomes for
// format-3 packets until the emitter flushes the snapshot.
module te_branch_map
    import mure_pkg::*;
#(
    parameter int N       = 1,
    parameter int MAP_LEN = BRANCH_MAP_LEN
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [N-1:0]                     valid_i,
    input  logic [N-1:0][ITYPE_LEN-1:0]      itype_i,
    output logic                             ready_o,
    input  logic                             flush_i,
    output logic [$clog2(MAP_LEN+1)-1:0]     branches_o,
    output logic [MAP_LEN-1:0]               branch_map_o,
    output logic                             full_o,
    output logic                             empty_o
);

    localparam int CNT_W = $clog2(MAP_LEN + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int NB_W  = $clog2(N + 1);

    logic [NB_W-1:0]    nb_s;
    logic [N-1:0]       outcome_s;
    logic [CNT_W-1:0]   base_s;
    logic [SUM_W-1:0]   sum_s;
    logic               ready_s;
    logic               accept_s;
    logic [MAP_LEN-1:0] kept_s;
    logic [MAP_LEN-1:0] new_bits_s;
    logic [CNT_W-1:0]   cnt_next_s;
    logic [MAP_LEN-1:0] map_next_s;

    logic [CNT_W-1:0]   branches_r;
    logic [MAP_LEN-1:0] map_r;
    logic               full_r;
    logic               empty_r;

    te_branch_lane_compactor #(
        .N    (N),
        .NB_W (NB_W)
    ) u_compactor (
        .valid   (valid_i),
        .itype   (itype_i),
        .nb      (nb_s),
        .outcome (outcome_s)
    );

    // Flush rebases the new branches at bit 0; a cycle is accepted whole or not at all.
    always_comb begin
        base_s     = flush_i ? {CNT_W{1'b0}} : branches_r;
        kept_s     = flush_i ? {MAP_LEN{1'b0}} : map_r;
        sum_s      = SUM_W'(base_s) + SUM_W'(nb_s);
        ready_s    = (sum_s <= SUM_W'(MAP_LEN));
        accept_s   = ready_s && (nb_s != {NB_W{1'b0}});
        new_bits_s = MAP_LEN'(outcome_s) << base_s;
        if (accept_s) begin
            cnt_next_s = CNT_W'(sum_s);
            map_next_s = kept_s | new_bits_s;
        end else begin
            cnt_next_s = base_s;
            map_next_s = kept_s;
        end
    end

    // Count, map and status flags all advance on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branches_r <= {CNT_W{1'b0}};
            map_r      <= {MAP_LEN{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
        end else begin
            branches_r <= cnt_next_s;
            map_r      <= map_next_s;
            full_r     <= (cnt_next_s == CNT_W'(MAP_LEN));
            empty_r    <= (cnt_next_s == {CNT_W{1'b0}});
        end
    end

    assign ready_o      = ready_s;
    assign branches_o   = branches_r;
    assign branch_map_o = map_r;
    assign full_o       = full_r;
    assign empty_o      = empty_r;

endmodule

// File: tb/tb_te_branch_map.sv
// Directed bench for te_branch_map with one single-lane and one dual-lane instance.
module tb_te_branch_map;
    import mure_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // single-lane instance
    logic                      v1 = 1'b0;
    logic [0:0][ITYPE_LEN-1:0] it1 = '0;
    logic                      f1 = 1'b0;
    logic                      rdy1, full1, empty1;
    logic [4:0]                cnt1;
    logic [30:0]               map1;

    // dual-lane instance
    logic [1:0]                v2 = 2'b00;
    logic [1:0][ITYPE_LEN-1:0] it2 = '0;
    logic                      f2 = 1'b0;
    logic                      rdy2, full2, empty2;
    logic [4:0]                cnt2;
    logic [30:0]               map2;

    int n_cmp = 0;
    int n_bad = 0;

    te_branch_map #(.N(1), .MAP_LEN(31)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v1), .itype_i(it1), .ready_o(rdy1),
        .flush_i(f1), .branches_o(cnt1), .branch_map_o(map1), .full_o(full1), .empty_o(empty1)
    );

    te_branch_map #(.N(2), .MAP_LEN(31)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v2), .itype_i(it2), .ready_o(rdy2),
        .flush_i(f2), .branches_o(cnt2), .branch_map_o(map2), .full_o(full2), .empty_o(empty2)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc1(input logic v, input logic [ITYPE_LEN-1:0] t, input logic f);
        v1 = v; it1[0] = t; f1 = f;
        @(posedge clk); #1;
        v1 = 1'b0; it1[0] = 3'd0; f1 = 1'b0;
    endtask

    task automatic cyc2(input logic [1:0] v, input logic [ITYPE_LEN-1:0] t0,
                        input logic [ITYPE_LEN-1:0] t1, input logic f);
        v2 = v; it2[0] = t0; it2[1] = t1; f2 = f;
        @(posedge clk); #1;
        v2 = 2'b00; it2[0] = 3'd0; it2[1] = 3'd0; f2 = 1'b0;
    endtask

    logic [ITYPE_LEN-1:0] ign_t [5] = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

    initial begin
        // reset and idle
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_cnt",   64'(cnt1),   64'd0);
        check_eq("rst_map",   64'(map1),   64'd0);
        check_eq("rst_empty", 64'(empty1), 64'd1);
        check_eq("rst_full",  64'(full1),  64'd0);
        check_eq("rst_ready", 64'(rdy1),   64'd1);
        check_eq("rst_cnt2",  64'(cnt2),   64'd0);

        // taken, not-taken, not-taken, taken
        cyc1(1'b1, ITYPE_TAKEN, 1'b0);
        check_eq("lat1_cnt", 64'(cnt1), 64'd1);
        cyc1(1'b1, ITYPE_NOT_TAKEN, 1'b0);
        cyc1(1'b1, ITYPE_NOT_TAKEN, 1'b0);
        cyc1(1'b1, ITYPE_TAKEN, 1'b0);
        check_eq("seq4_cnt",   64'(cnt1),   64'd4);
        check_eq("seq4_map",   64'(map1),   64'h6);
        check_eq("seq4_empty", 64'(empty1), 64'd0);

        // flush without branches
        cyc1(1'b0, 3'd0, 1'b1);
        check_eq("fl0_cnt",   64'(cnt1),   64'd0);
        check_eq("fl0_map",   64'(map1),   64'd0);
        check_eq("fl0_empty", 64'(empty1), 64'd1);
        cyc1(1'b0, 3'd0, 1'b1);
        check_eq("fl_idle_cnt", 64'(cnt1), 64'd0);

        // asynchronous reset mid-fill at count 7
        for (int i = 0; i < 7; i++) cyc1(1'b1, ITYPE_NOT_TAKEN, 1'b0);
        check_eq("mid_cnt7", 64'(cnt1), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_cnt",   64'(cnt1),   64'd0);
        check_eq("arst_map",   64'(map1),   64'd0);
        check_eq("arst_empty", 64'(empty1), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // fill to capacity
        for (int i = 0; i < 31; i++) cyc1(1'b1, ITYPE_NOT_TAKEN, 1'b0);
        check_eq("full_cnt",  64'(cnt1),  64'd31);
        check_eq("full_map",  64'(map1),  64'h7FFFFFFF);
        check_eq("full_flag", 64'(full1), 64'd1);
        check_eq("full_empty", 64'(empty1), 64'd0);

        // 32nd branch rejected
        v1 = 1'b1; it1[0] = ITYPE_TAKEN; f1 = 1'b0;
        #1;
        check_eq("ovf_ready", 64'(rdy1), 64'd0);
        @(posedge clk); #1;
        check_eq("ovf_cnt", 64'(cnt1), 64'd31);
        check_eq("ovf_map", 64'(map1), 64'h7FFFFFFF);
        check_eq("ovf_full", 64'(full1), 64'd1);

        // flush plus taken branch from full
        f1 = 1'b1;
        #1;
        check_eq("flb_ready", 64'(rdy1), 64'd1);
        @(posedge clk); #1;
        v1 = 1'b0; it1[0] = 3'd0; f1 = 1'b0;
        check_eq("flb_cnt",  64'(cnt1),  64'd1);
        check_eq("flb_map",  64'(map1),  64'd0);
        check_eq("flb_full", 64'(full1), 64'd0);
        cyc1(1'b0, 3'd0, 1'b1);
        check_eq("fl2_cnt",   64'(cnt1),   64'd0);
        check_eq("fl2_empty", 64'(empty1), 64'd1);

        // ignored lanes on the single-lane instance
        cyc1(1'b1, ITYPE_TAKEN, 1'b0);
        cyc1(1'b1, ITYPE_NOT_TAKEN, 1'b0);
        v1 = 1'b0; it1[0] = ITYPE_TAKEN;
        #1;
        check_eq("inv_ready", 64'(rdy1), 64'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            v1 = 1'b1; it1[0] = ign_t[i];
            #1;
            check_eq("ign_ready", 64'(rdy1), 64'd1);
            @(posedge clk); #1;
        end
        v1 = 1'b0; it1[0] = 3'd0;
        check_eq("ign_cnt", 64'(cnt1), 64'd2);
        check_eq("ign_map", 64'(map1), 64'h2);

        // dual-lane: reach count 30 with lane0 taken, lane1 not taken
        for (int i = 0; i < 15; i++) cyc2(2'b11, ITYPE_TAKEN, ITYPE_NOT_TAKEN, 1'b0);
        check_eq("n2_cnt30", 64'(cnt2), 64'd30);
        check_eq("n2_map30", 64'(map2), 64'h2AAAAAAA);

        // two branches would overflow
        v2 = 2'b11; it2[0] = ITYPE_NOT_TAKEN; it2[1] = ITYPE_NOT_TAKEN;
        #1;
        check_eq("n2_rej_ready", 64'(rdy2), 64'd0);
        @(posedge clk); #1;
        check_eq("n2_rej_cnt", 64'(cnt2), 64'd30);
        check_eq("n2_rej_map", 64'(map2), 64'h2AAAAAAA);

        // lane0 branch, lane1 itype 0
        it2[1] = 3'd0;
        #1;
        check_eq("n2_one_ready", 64'(rdy2), 64'd1);
        @(posedge clk); #1;
        v2 = 2'b00; it2[0] = 3'd0;
        check_eq("n2_one_cnt",  64'(cnt2),  64'd31);
        check_eq("n2_one_map",  64'(map2),  64'h6AAAAAAA);
        check_eq("n2_one_full", 64'(full2), 64'd1);

        // flush with both lanes taken
        v2 = 2'b11; it2[0] = ITYPE_TAKEN; it2[1] = ITYPE_TAKEN; f2 = 1'b1;
        #1;
        check_eq("n2_flb_ready", 64'(rdy2), 64'd1);
        @(posedge clk); #1;
        v2 = 2'b00; it2[0] = 3'd0; it2[1] = 3'd0; f2 = 1'b0;
        check_eq("n2_flb_cnt",  64'(cnt2),  64'd2);
        check_eq("n2_flb_map",  64'(map2),  64'd0);
        check_eq("n2_flb_full", 64'(full2), 64'd0);

        // lane ordering: lane0 invalid taken, lane1 not taken
        cyc2(2'b10, ITYPE_TAKEN, ITYPE_NOT_TAKEN, 1'b0);
        check_eq("n2_l1_cnt", 64'(cnt2), 64'd3);
        check_eq("n2_l1_map", 64'(map2), 64'h4);
        cyc2(2'b11, ITYPE_NOT_TAKEN, ITYPE_TAKEN, 1'b0);
        check_eq("n2_ord_cnt", 64'(cnt2), 64'd5);
        check_eq("n2_ord_map", 64'(map2), 64'hC);
        cyc2(2'b11, 3'd6, 3'd2, 1'b0);
        check_eq("n2_ign_cnt", 64'(cnt2), 64'd5);
        check_eq("n2_ign_map", 64'(map2), 64'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/te_branch_map.md
Name: te_branch_map

Overview:
- Branch-map accumulator inside the trace encoder, directly downstream of the CPU-to-encoder connector.
- Consumes the per-cycle blocks (valid_o/itype_o) that the connector produces.
- Records taken/not-taken outcomes of retired conditional branches into a 31-entry map for E-Trace format-3 (branch) packets.
- Tells the packet emitter when the map is full; the emitter clears the map via flush.

Parameters:
- N, 1, number of block lanes per cycle (matches the connector's N); legal range 1..4.
- MAP_LEN, 31, branch map capacity in entries (E-Trace maximum).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  N  per-lane block valid.
- itype_i  in  N x mure_pkg::ITYPE_LEN  per-lane itype; 4 = not-taken branch, 5 = taken branch.
- ready_o  out  1  this cycle's lanes are accepted.
- flush_i  in  1  emitter has consumed the current snapshot; clear map at next edge.
- branches_o  out  $clog2(MAP_LEN+1)  registered count of recorded branches.
- branch_map_o  out  MAP_LEN  registered map; bit k is the k-th oldest branch; 1 = not taken, 0 = taken.
- full_o  out  1  registered; branches_o == MAP_LEN.
- empty_o  out  1  registered; branches_o == 0.

Behaviour:
- Reset: branches_o=0, branch_map_o=0, full_o=0, empty_o=1. Outputs are forced to these values asynchronously whenever rst_ni is low, including mid-operation.
- Branch lane: valid_i[k]=1 and itype_i[k] is 4 or 5. All other lanes (invalid, or itype 0-3, 6+) are ignored and never affect the map.
- nb: number of branch lanes this cycle, 0..N.
- base: 0 if flush_i=1, else branches_o.
- ready_o (combinational) = (base + nb <= MAP_LEN). It is 1 whenever nb = 0.
- Accept: ready_o=1 and nb>0. At the clock edge the branch lanes are written in ascending lane order into bits base, base+1, …; branches_o <= base+nb.
- Reject: ready_o=0. No lane of the cycle is recorded (all-or-nothing). State changes only if flush_i=1. Upstream holds its lanes until ready_o=1.
- Flush without branches: branches_o <= 0, branch_map_o <= 0.
- Flush with branches in the same cycle: the old map is discarded and the new branches start at bit 0. Flush has priority over retention, never over the new data.
- Map bits at index >= branches_o are always 0. Flushed bits are cleared, not left stale.
- full_o and empty_o derive from the next-state count. They are registered and update in the same edge as branches_o.
- Latency: an accepted branch is visible on branch_map_o/branches_o one cycle after acceptance.
- flush_i while empty: no effect, no error.
- Wrap-around: the count never exceeds MAP_LEN. Overflow is impossible by construction; verification asserts it.
- Count arithmetic uses width $clog2(MAP_LEN+1)+1 so base+nb cannot wrap. Results are truncated on register write.

Decomposition:
- mure_pkg gains:
  - BRANCH_MAP_LEN = 31.
  - BRANCH_CNT_LEN = 5.
  - Named itype constants ITYPE_NOT_TAKEN = 4 and ITYPE_TAKEN = 5, used instead of literals.
- One sub-module is natural: te_branch_lane_compactor. It is combinational and, given valid_i/itype_i, produces nb and a packed vector of up to N outcome bits in lane order.
- Top-level te_branch_map holds the counter, map register, ready logic and flush priority.

Test Plan:
- Reset then idle: check branches_o=0, map=0, empty_o=1, full_o=0, ready_o=1. Assert rst_ni mid-fill (count 7) → outputs return to reset values immediately.
- N=1: feed taken, not-taken, not-taken, taken → branches_o=4, branch_map_o[3:0]=4'b0110, empty_o=0.
- N=1: 31 not-taken branches → branches_o=31, map=31'h7FFFFFFF, full_o=1. Then present a 32nd branch with flush_i=0 → ready_o=0, state unchanged.
- From full: flush_i=1 with a taken branch in the same cycle → next cycle branches_o=1, map=0, full_o=0. Flush with no branch → branches_o=0, empty_o=1.
- N=2 with count 30:
  - both lanes branches → ready_o=0, nothing recorded.
  - lane0 branch, lane1 itype 0 → accepted, count 31.
  - flush_i=1 with both lanes taken → count 2, map bits 0-1 = 0.
- Lanes with valid_i=0 but itype 5, and lanes with itype 1/2/3/6: no change to count or map, ready_o=1.
